// File: rtl/ingreso_monto_pkg.sv
// Shared definitions for the ATM amount-entry stage: key codes, data width and FSM states.
package ingreso_monto_pkg;

    localparam int MONTO_W = 32;

    localparam logic [3:0] TECLA_BORRAR   = 4'hA;
    localparam logic [3:0] TECLA_CANCELAR = 4'hC;
    localparam logic [3:0] TECLA_ACEPTAR  = 4'hE;

    typedef enum logic [1:0] {
        INACTIVO    = 2'd0,
        CAPTURA     = 2'd1,
        ESPERA_BAJA = 2'd2
    } estado_t;

    function automatic logic es_numero(input logic [3:0] tecla);
        return tecla <= 4'd9;
    endfunction

endpackage

// File: rtl/ingreso_monto_acumulador_decimal.sv
// Decimal accumulator: shifts a new digit into a binary value (acc*10 + digit) and counts digits.
module acumulador_decimal
    import ingreso_monto_pkg::*;
#(
    parameter int MAX_DIGITOS = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cargar,
    input  logic               limpiar,
    input  logic [3:0]         digito,
    output logic [MONTO_W-1:0] acc,
    output logic [3:0]         contador,
    output logic               lleno
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITOS);

    // x10 built from two shifts so no multiplier is inferred
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            contador <= '0;
        end else if (limpiar) begin
            acc      <= '0;
            contador <= '0;
        end else if (cargar) begin
            acc      <= (acc << 3) + (acc << 1) + {{(MONTO_W-4){1'b0}}, digito};
            contador <= contador + 4'd1;
        end
    end

    assign lleno = (contador >= MAX_CNT);

endmodule

// File: rtl/ingreso_monto.sv
// Keypad amount entry: FSM, idle timeout and registered pulses around the decimal accumulator.
module ingreso_monto
    import ingreso_monto_pkg::*;
#(
    parameter int MAX_DIGITOS    = 9,
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               habilitar,
    input  logic               digito_stb,
    input  logic [3:0]         digito,
    output logic [MONTO_W-1:0] monto,
    output logic               monto_stb,
    output logic               cancelado,
    output logic               error_tecla,
    output logic [3:0]         digitos_ingresados
);

    localparam int            TW        = $clog2(TIMEOUT_CICLOS);
    localparam logic [TW-1:0] TIMER_FIN = TW'(TIMEOUT_CICLOS - 1);

    estado_t            estado;
    logic [TW-1:0]      timer;
    logic [MONTO_W-1:0] acc;
    logic [3:0]         contador;
    logic               lleno;
    logic               tecla_valida;
    logic               cero_inicial;
    logic               cargar;
    logic               limpiar;

    // Losing habilitar in CAPTURA outranks any strobe in the same cycle
    always_comb begin
        tecla_valida = 1'b0;
        cero_inicial = 1'b0;
        cargar       = 1'b0;
        limpiar      = 1'b0;
        tecla_valida = (estado == CAPTURA) && habilitar && digito_stb;
        cero_inicial = (acc == '0) && (digito == 4'd0);
        cargar       = tecla_valida && es_numero(digito) && !cero_inicial && !lleno;
        limpiar      = ((estado == INACTIVO) && habilitar) ||
                       ((estado == CAPTURA) && !habilitar) ||
                       (tecla_valida && (digito == TECLA_BORRAR));
    end

    acumulador_decimal #(
        .MAX_DIGITOS (MAX_DIGITOS)
    ) u_acumulador (
        .clk      (clk),
        .reset    (reset),
        .cargar   (cargar),
        .limpiar  (limpiar),
        .digito   (digito),
        .acc      (acc),
        .contador (contador),
        .lleno    (lleno)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado      <= INACTIVO;
            timer       <= '0;
            monto       <= '0;
            monto_stb   <= 1'b0;
            cancelado   <= 1'b0;
            error_tecla <= 1'b0;
        end else begin
            monto_stb   <= 1'b0;
            cancelado   <= 1'b0;
            error_tecla <= 1'b0;
            case (estado)
                INACTIVO: begin
                    timer <= '0;
                    if (habilitar) begin
                        estado <= CAPTURA;
                    end
                end
                CAPTURA: begin
                    if (!habilitar) begin
                        estado <= INACTIVO;
                        timer  <= '0;
                    end else if (digito_stb) begin
                        timer <= '0;
                        case (digito)
                            TECLA_BORRAR: begin
                            end
                            TECLA_CANCELAR: begin
                                cancelado <= 1'b1;
                                estado    <= ESPERA_BAJA;
                            end
                            TECLA_ACEPTAR: begin
                                if (contador == 4'd0) begin
                                    error_tecla <= 1'b1;
                                end else begin
                                    monto     <= acc;
                                    monto_stb <= 1'b1;
                                    estado    <= ESPERA_BAJA;
                                end
                            end
                            4'hB, 4'hD, 4'hF: begin
                                error_tecla <= 1'b1;
                            end
                            default: begin
                                if (lleno && !cero_inicial) begin
                                    error_tecla <= 1'b1;
                                end
                            end
                        endcase
                    end else if (timer == TIMER_FIN) begin
                        cancelado <= 1'b1;
                        estado    <= ESPERA_BAJA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ESPERA_BAJA: begin
                    timer <= '0;
                    if (!habilitar) begin
                        estado <= INACTIVO;
                    end
                end
                default: begin
                    estado <= INACTIVO;
                    timer  <= '0;
                end
            endcase
        end
    end

    assign digitos_ingresados = (estado == CAPTURA) ? contador : 4'd0;

endmodule

// File: tb/tb_ingreso_monto.sv
// Self-checking bench for ingreso_monto: pulse checks inline, accepted amounts via a scoreboard queue.
module tb_ingreso_monto;
    import ingreso_monto_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        habilitar;
    logic        digito_stb;
    logic [3:0]  digito;
    logic [31:0] monto;
    logic        monto_stb;
    logic        cancelado;
    logic        error_tecla;
    logic [3:0]  digitos_ingresados;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] sb[$];
    logic [31:0] exp_monto;
    logic        obs_err, obs_can, obs_stb;

    ingreso_monto #(
        .MAX_DIGITOS    (9),
        .TIMEOUT_CICLOS (16)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .habilitar          (habilitar),
        .digito_stb         (digito_stb),
        .digito             (digito),
        .monto              (monto),
        .monto_stb          (monto_stb),
        .cancelado          (cancelado),
        .error_tecla        (error_tecla),
        .digitos_ingresados (digitos_ingresados)
    );

    always #5 clk = ~clk;

    // Scoreboard: every monto_stb must match the oldest expected amount
    always @(negedge clk) begin
        if (reset === 1'b1 && monto_stb === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("[TB] FAIL monto_stb_unexpected: got monto=%0d with no amount expected", monto);
            end else begin
                exp_monto = sb.pop_front();
                if (monto !== exp_monto) begin
                    bad++;
                    $display("[TB] FAIL monto_value: got %0d expected %0d", monto, exp_monto);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic press_key(input logic [3:0] k);
        @(negedge clk);
        digito     = k;
        digito_stb = 1'b1;
        @(negedge clk);
        digito_stb = 1'b0;
        obs_err    = error_tecla;
        obs_can    = cancelado;
        obs_stb    = monto_stb;
    endtask

    task automatic enable_entry();
        @(negedge clk);
        habilitar = 1'b1;
        @(negedge clk);
    endtask

    task automatic disable_entry();
        @(negedge clk);
        habilitar = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        total++;
        if ({monto, monto_stb, cancelado, error_tecla, digitos_ingresados} !== 39'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got monto=%0d stb=%b can=%b err=%b dig=%0d expected all 0",
                     monto, monto_stb, cancelado, error_tecla, digitos_ingresados);
        end
        @(negedge clk);
        reset = 1'b1;
        enable_entry();
        press_key(4'd3);
        press_key(4'd7);
        total++;
        if (digitos_ingresados !== 4'd2) begin
            bad++;
            $display("[TB] FAIL reset_pre_digits: got %0d expected 2", digitos_ingresados);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({monto, monto_stb, cancelado, error_tecla, digitos_ingresados} !== 39'd0) begin
            bad++;
            $display("[TB] FAIL reset_async: got monto=%0d dig=%0d expected all 0", monto, digitos_ingresados);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        press_key(TECLA_ACEPTAR);
        total++;
        if ({obs_err, obs_can, obs_stb} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL reset_no_stale: got err/can/stb=%b%b%b expected 100", obs_err, obs_can, obs_stb);
        end
        disable_entry();
    endtask

    task automatic test_basic();
        logic [3:0] keys [5];
        keys = '{4'd1, 4'd2, 4'd5, 4'd0, TECLA_ACEPTAR};
        enable_entry();
        for (int i = 0; i < 5; i++) begin
            if (keys[i] == TECLA_ACEPTAR) begin
                total++;
                if (digitos_ingresados !== 4'd4) begin
                    bad++;
                    $display("[TB] FAIL basic_digits: got %0d expected 4", digitos_ingresados);
                end
                sb.push_back(32'd1250);
            end
            press_key(keys[i]);
            total++;
            if ({obs_err, obs_can, obs_stb} !== {2'b00, keys[i] == TECLA_ACEPTAR}) begin
                bad++;
                $display("[TB] FAIL basic_key%0d: got err/can/stb=%b%b%b", i, obs_err, obs_can, obs_stb);
            end
        end
        @(negedge clk);
        total++;
        if ({monto_stb, digitos_ingresados, monto} !== {1'b0, 4'd0, 32'd1250}) begin
            bad++;
            $display("[TB] FAIL basic_hold: got stb=%b dig=%0d monto=%0d expected 0 0 1250",
                     monto_stb, digitos_ingresados, monto);
        end
        disable_entry();
    endtask

    task automatic test_full();
        enable_entry();
        for (int i = 0; i < 10; i++) begin
            press_key(4'd9);
            total++;
            if (obs_err !== (i == 9)) begin
                bad++;
                $display("[TB] FAIL full_nine%0d: got error_tecla=%b expected %b", i, obs_err, i == 9);
            end
        end
        @(negedge clk);
        total++;
        if ({error_tecla, digitos_ingresados} !== {1'b0, 4'd9}) begin
            bad++;
            $display("[TB] FAIL full_after: got err=%b dig=%0d expected 0 9", error_tecla, digitos_ingresados);
        end
        sb.push_back(32'd999999999);
        press_key(TECLA_ACEPTAR);
        total++;
        if ({obs_err, obs_can, obs_stb} !== 3'b001) begin
            bad++;
            $display("[TB] FAIL full_accept: got err/can/stb=%b%b%b expected 001", obs_err, obs_can, obs_stb);
        end
        disable_entry();
    endtask

    task automatic test_error_keys();
        logic [3:0] keys [6];
        logic [2:0] expv [6];
        logic [3:0] digs [6];
        keys = '{TECLA_ACEPTAR, 4'hB, 4'd0, 4'd0, 4'd7, TECLA_ACEPTAR};
        expv = '{3'b100, 3'b100, 3'b000, 3'b000, 3'b000, 3'b001};
        digs = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0};
        enable_entry();
        for (int i = 0; i < 6; i++) begin
            if (expv[i][0]) sb.push_back(32'd7);
            press_key(keys[i]);
            total++;
            if ({obs_err, obs_can, obs_stb, digitos_ingresados} !== {expv[i], digs[i]}) begin
                bad++;
                $display("[TB] FAIL errkeys_step%0d: got err/can/stb=%b%b%b dig=%0d expected %b dig=%0d",
                         i, obs_err, obs_can, obs_stb, digitos_ingresados, expv[i], digs[i]);
            end
        end
        disable_entry();
        enable_entry();
        press_key(4'd3);
        press_key(TECLA_BORRAR);
        total++;
        if ({obs_err, digitos_ingresados} !== {1'b0, 4'd0}) begin
            bad++;
            $display("[TB] FAIL errkeys_clear: got err=%b dig=%0d expected 0 0", obs_err, digitos_ingresados);
        end
        press_key(4'd4);
        sb.push_back(32'd4);
        press_key(TECLA_ACEPTAR);
        total++;
        if (obs_stb !== 1'b1) begin
            bad++;
            $display("[TB] FAIL errkeys_accept4: got monto_stb=%b expected 1", obs_stb);
        end
        disable_entry();
    endtask

    task automatic test_cancel();
        enable_entry();
        press_key(4'd8);
        press_key(TECLA_CANCELAR);
        total++;
        if ({obs_err, obs_can, obs_stb, monto} !== {3'b010, 32'd4}) begin
            bad++;
            $display("[TB] FAIL cancel_pulse: got err/can/stb=%b%b%b monto=%0d expected 010 4",
                     obs_err, obs_can, obs_stb, monto);
        end
        @(negedge clk);
        total++;
        if (cancelado !== 1'b0) begin
            bad++;
            $display("[TB] FAIL cancel_width: got cancelado=%b expected 0", cancelado);
        end
        press_key(4'd5);
        press_key(TECLA_ACEPTAR);
        total++;
        if ({obs_err, obs_can, obs_stb, digitos_ingresados} !== 7'd0) begin
            bad++;
            $display("[TB] FAIL cancel_ignored: got err/can/stb=%b%b%b dig=%0d expected 000 0",
                     obs_err, obs_can, obs_stb, digitos_ingresados);
        end
        disable_entry();
        enable_entry();
        press_key(4'd6);
        @(negedge clk);
        habilitar  = 1'b0;
        digito     = TECLA_ACEPTAR;
        digito_stb = 1'b1;
        @(negedge clk);
        digito_stb = 1'b0;
        total++;
        if ({monto_stb, error_tecla, cancelado, digitos_ingresados, monto} !== {7'd0, 32'd4}) begin
            bad++;
            $display("[TB] FAIL cancel_enter_lost: got stb=%b err=%b can=%b dig=%0d monto=%0d expected 0 0 0 0 4",
                     monto_stb, error_tecla, cancelado, digitos_ingresados, monto);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        for (int pass = 0; pass < 2; pass++) begin
            enable_entry();
            press_key(4'd5);
            if (pass == 1) begin
                repeat (14) @(negedge clk);
                press_key(4'd6);
                total++;
                if (obs_can !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL timeout_strobe_priority: got cancelado=%b expected 0", obs_can);
                end
            end
            n = 0;
            for (int i = 1; i <= 40 && n == 0; i++) begin
                @(negedge clk);
                if (cancelado === 1'b1) n = i;
            end
            total++;
            if (n !== 16) begin
                bad++;
                $display("[TB] FAIL timeout_pass%0d: cancelado after %0d cycles expected 16 (0 = never)", pass, n);
            end
            disable_entry();
        end
    endtask

    initial begin
        reset      = 1'b0;
        habilitar  = 1'b0;
        digito_stb = 1'b0;
        digito     = 4'd0;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_full();
        test_error_keys();
        test_cancel();
        test_timeout();
        repeat (3) @(negedge clk);
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: %0d expected amounts never published, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
